// File: rtl/fb_scanout_arbiter.sv
// fb_scanout_arbiter: framebuffer scanout line fetcher with draw-engine arbitration onto one memory port.
// Ports:
//   clk_pix, rst                       pixel clock, synchronous active-high reset
//   frame, line, sy                    start-of-frame / start-of-line pulses, signed line being displayed
//   drw_valid/ready/we/addr/wdata      draw-engine request, granted only while not fetching
//   drw_rdata, drw_rvalid              draw read data, one cycle after grant
//   mem_en/we/addr/wdata, mem_rdata    shared memory port, read data one cycle after mem_en
//   lb_we, lb_addr, lb_data            line-buffer write, lb_addr MSB selects the bank (row parity)
//   line_done, busy, underrun          last-pixel pulse, fetch in progress, sticky restart flag
module fb_scanout_arbiter #(
  parameter int CORDW = 16,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int ADDRW = 19,
  parameter int DATAW = 8
) (
  input  logic                      clk_pix,
  input  logic                      rst,
  input  logic                      frame,
  input  logic                      line,
  input  logic signed [CORDW-1:0]   sy,
  input  logic                      drw_valid,
  output logic                      drw_ready,
  input  logic                      drw_we,
  input  logic [ADDRW-1:0]          drw_addr,
  input  logic [DATAW-1:0]          drw_wdata,
  output logic [DATAW-1:0]          drw_rdata,
  output logic                      drw_rvalid,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDRW-1:0]          mem_addr,
  output logic [DATAW-1:0]          mem_wdata,
  input  logic [DATAW-1:0]          mem_rdata,
  output logic                      lb_we,
  output logic [$clog2(H_RES):0]    lb_addr,
  output logic [DATAW-1:0]          lb_data,
  output logic                      line_done,
  output logic                      busy,
  output logic                      underrun
);
  localparam int IW = $clog2(H_RES);
  localparam logic [IW-1:0] LAST = IW'(H_RES - 1);
  localparam logic [ADDRW-1:0] HA = ADDRW'(H_RES);
  localparam logic signed [CORDW-1:0] SY_MAX = CORDW'(V_RES - 2);
  typedef enum logic {IDLE, FETCH} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [ADDRW-1:0] base, base_n, line_base;
  logic bank, bank_n;
  logic ret_v, ret_f, ret_last, under_q;
  logic [IW:0] ret_addr;
  logic fetch, line_ok, load;
  assign fetch = state == FETCH;
  // the last displayed line has no successor to prefetch, and off-screen lines are ignored
  assign line_ok = line && !sy[CORDW-1] && sy <= SY_MAX;
  assign load = frame || line_ok;
  assign line_base = (ADDRW'(sy) + ADDRW'(1)) * HA;
  // a load while already fetching restarts at pixel 0 of the new row (underrun)
  always_comb begin
    state_n = state;
    idx_n = idx;
    base_n = base;
    bank_n = bank;
    if (load) begin
      state_n = FETCH;
      idx_n = '0;
      base_n = frame ? '0 : line_base;
      bank_n = !frame && !sy[0];
    end else if (fetch) begin
      idx_n = idx + 1'b1;
      state_n = idx == LAST ? IDLE : FETCH;
    end
  end
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      base <= '0;
      bank <= 1'b0;
      ret_v <= 1'b0;
      ret_f <= 1'b0;
      ret_last <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      base <= base_n;
      bank <= bank_n;
      ret_v <= mem_en && !mem_we;
      ret_f <= fetch;
      ret_last <= fetch && idx == LAST && !load;
      under_q <= under_q || (fetch && load);
    end
  end
  always_ff @(posedge clk_pix) ret_addr <= {bank, idx};
  assign drw_ready = rst || !fetch;
  assign busy = !rst && fetch;
  assign mem_en = !rst && (fetch || drw_valid);
  assign mem_we = !rst && !fetch && drw_valid && drw_we;
  assign mem_addr = fetch ? base + ADDRW'(idx) : drw_addr;
  assign mem_wdata = drw_wdata;
  assign lb_we = !rst && ret_v && ret_f;
  assign lb_addr = ret_addr;
  assign lb_data = mem_rdata;
  assign line_done = lb_we && ret_last;
  assign drw_rvalid = !rst && ret_v && !ret_f;
  assign drw_rdata = mem_rdata;
  assign underrun = !rst && under_q;
endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// tb_fb_scanout_arbiter: vectors, corner sequences and random traffic against a behavioural model.
module tb_fb_scanout_arbiter;
  localparam int CORDW = 16, H_RES = 8, V_RES = 4, ADDRW = 5, DATAW = 8;
  localparam int LBW = $clog2(H_RES) + 1;
  logic clk_pix = 1'b0, rst = 1'b1, frame = 1'b0, line = 1'b0;
  logic signed [CORDW-1:0] sy = '0;
  logic drw_valid = 1'b0, drw_ready, drw_we = 1'b0, drw_rvalid;
  logic [ADDRW-1:0] drw_addr = '0, mem_addr;
  logic [DATAW-1:0] drw_wdata = '0, drw_rdata, mem_wdata, mem_rdata, lb_data;
  logic mem_en, mem_we, lb_we, line_done, busy, underrun;
  logic [LBW-1:0] lb_addr;
  logic [DATAW-1:0] mem [1<<ADDRW];
  int checks = 0, errors = 0;
  fb_scanout_arbiter #(.CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES), .ADDRW(ADDRW), .DATAW(DATAW)) dut (
    .clk_pix(clk_pix), .rst(rst), .frame(frame), .line(line), .sy(sy),
    .drw_valid(drw_valid), .drw_ready(drw_ready), .drw_we(drw_we), .drw_addr(drw_addr),
    .drw_wdata(drw_wdata), .drw_rdata(drw_rdata), .drw_rvalid(drw_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data), .line_done(line_done), .busy(busy), .underrun(underrun)
  );
  always #5 clk_pix = ~clk_pix;
  always @(posedge clk_pix)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  function automatic logic [DATAW-1:0] init_val(int k);
    return DATAW'(k * 37 + 11);
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: row/pixel counters with explicit multiply, one pending memory return
  bit m_fetch = 0, m_under = 0, m_rv = 0, m_rf = 0, m_rlast = 0;
  int m_row = 0, m_pos = 0, m_raddr = 0;
  logic [DATAW-1:0] m_rdata = '0;
  always @(negedge clk_pix) begin : model
    bit e_en, e_we, q;
    int nrow;
    logic [ADDRW-1:0] e_addr;
    if (rst) begin
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(drw_ready), 1);
      chk("rst_mem_en", int'(mem_en), 0);
      chk("rst_mem_we", int'(mem_we), 0);
      chk("rst_lb_we", int'(lb_we), 0);
      chk("rst_line_done", int'(line_done), 0);
      chk("rst_rvalid", int'(drw_rvalid), 0);
      chk("rst_underrun", int'(underrun), 0);
      m_fetch = 0; m_under = 0; m_rv = 0; m_rf = 0; m_rlast = 0;
    end else begin
      e_en = m_fetch || drw_valid;
      e_we = !m_fetch && drw_valid && drw_we;
      e_addr = m_fetch ? ADDRW'((m_row * H_RES + m_pos) % (1 << ADDRW)) : drw_addr;
      chk("busy", int'(busy), int'(m_fetch));
      chk("drw_ready", int'(drw_ready), int'(!m_fetch));
      chk("mem_en", int'(mem_en), int'(e_en));
      if (e_en) begin
        chk("mem_we", int'(mem_we), int'(e_we));
        chk("mem_addr", int'(mem_addr), int'(e_addr));
      end
      if (e_we) chk("mem_wdata", int'(mem_wdata), int'(drw_wdata));
      chk("lb_we", int'(lb_we), int'(m_rv && m_rf));
      chk("line_done", int'(line_done), int'(m_rv && m_rf && m_rlast));
      chk("drw_rvalid", int'(drw_rvalid), int'(m_rv && !m_rf));
      if (m_rv && m_rf) begin
        chk("lb_addr", int'(lb_addr), m_raddr);
        chk("lb_data", int'(lb_data), int'(m_rdata));
      end
      if (m_rv && !m_rf) chk("drw_rdata", int'(drw_rdata), int'(m_rdata));
      chk("underrun", int'(underrun), int'(m_under));
      q = frame || (line && int'(sy) >= 0 && int'(sy) <= V_RES - 2);
      nrow = frame ? 0 : int'(sy) + 1;
      m_rv = e_en && !e_we;
      m_rf = m_fetch;
      m_rdata = mem[e_addr];
      m_raddr = (m_row % 2) * H_RES + m_pos;
      m_rlast = m_fetch && m_pos == H_RES - 1 && !q;
      if (q) begin
        if (m_fetch) m_under = 1;
        m_fetch = 1; m_row = nrow; m_pos = 0;
      end else if (m_fetch) begin
        m_pos++;
        if (m_pos == H_RES) m_fetch = 0;
      end
    end
  end
  task automatic step();
    @(posedge clk_pix); #1;
  endtask
  task automatic pulse(bit f, bit l, int s);
    frame = f; line = l; sy = CORDW'(s);
    step();
    frame = 0; line = 0;
  endtask
  typedef struct {bit f; bit l; int s; bit go; int base; int bank;} vec_t;
  vec_t tbl[10];
  initial begin
    bit acc;
    for (int k = 0; k < (1 << ADDRW); k++) mem[k] = init_val(k);
    tbl[0] = '{1, 0, 0, 1, 0, 0};
    tbl[1] = '{0, 1, 0, 1, 8, 1};
    tbl[2] = '{0, 1, 1, 1, 16, 0};
    tbl[3] = '{0, 1, 2, 1, 24, 1};
    tbl[4] = '{0, 1, 3, 0, 0, 0};
    tbl[5] = '{0, 1, -1, 0, 0, 0};
    tbl[6] = '{0, 1, 4, 0, 0, 0};
    tbl[7] = '{0, 1, 100, 0, 0, 0};
    tbl[8] = '{1, 1, 3, 1, 0, 0};
    tbl[9] = '{1, 1, 1, 1, 0, 0};
    rst = 1; drw_valid = 1; drw_addr = 5;
    repeat (3) begin
      @(negedge clk_pix);
      chk("reset_busy", int'(busy), 0);
      chk("reset_underrun", int'(underrun), 0);
      chk("reset_ready", int'(drw_ready), 1);
      chk("reset_lb_we", int'(lb_we), 0);
    end
    step();
    rst = 0; drw_valid = 0;
    step(); step();
    foreach (tbl[n]) begin
      pulse(tbl[n].f, tbl[n].l, tbl[n].s);
      for (int c = 1; c <= H_RES + 1; c++) begin
        @(negedge clk_pix);
        if (tbl[n].go) begin
          chk("vec_busy", int'(busy), int'(c <= H_RES));
          if (c <= H_RES) chk("vec_addr", int'(mem_addr), tbl[n].base + c - 1);
          if (c >= 2) chk("vec_lb_addr", int'(lb_addr), tbl[n].bank * H_RES + c - 2);
          chk("vec_line_done", int'(line_done), int'(c == H_RES + 1));
        end else begin
          chk("vec_idle_busy", int'(busy), 0);
          chk("vec_idle_mem_en", int'(mem_en), 0);
        end
        step();
      end
    end
    frame = 1; drw_valid = 1; drw_we = 1; drw_addr = 3; drw_wdata = 8'hA5;
    @(negedge clk_pix);
    chk("arb_same_cycle_ready", int'(drw_ready), 1);
    chk("arb_same_cycle_we", int'(mem_we), 1);
    chk("arb_same_cycle_addr", int'(mem_addr), 3);
    step();
    frame = 0; drw_we = 0; drw_addr = 20;
    for (int c = 1; c <= H_RES; c++) begin
      @(negedge clk_pix);
      chk("arb_hold_ready", int'(drw_ready), 0);
      if (c == 1) chk("arb_write_no_rvalid", int'(drw_rvalid), 0);
      step();
    end
    @(negedge clk_pix);
    chk("arb_drain_ready", int'(drw_ready), 1);
    chk("arb_drain_addr", int'(mem_addr), 20);
    chk("arb_drain_lb_we", int'(lb_we), 1);
    step();
    drw_valid = 0;
    @(negedge clk_pix);
    chk("arb_rvalid", int'(drw_rvalid), 1);
    chk("arb_rdata", int'(drw_rdata), int'(init_val(20)));
    step();
    drw_valid = 1; drw_addr = 3;
    step();
    drw_valid = 0;
    @(negedge clk_pix);
    chk("arb_readback", int'(drw_rdata), 8'hA5);
    step();
    pulse(1, 0, 0);
    repeat (3) step();
    line = 1; sy = 0;
    @(negedge clk_pix);
    chk("ur_issue3", int'(mem_addr), 3);
    chk("ur_before", int'(underrun), 0);
    step();
    line = 0;
    @(negedge clk_pix);
    chk("ur_set", int'(underrun), 1);
    chk("ur_restart_addr", int'(mem_addr), 8);
    chk("ur_last_return", int'(lb_addr), 3);
    chk("ur_no_done", int'(line_done), 0);
    step();
    for (int c = 6; c <= 12; c++) begin
      @(negedge clk_pix);
      chk("ur_addr", int'(mem_addr), 8 + c - 5);
      chk("ur_no_done", int'(line_done), 0);
      step();
    end
    @(negedge clk_pix);
    chk("ur_done", int'(line_done), 1);
    chk("ur_done_lb_addr", int'(lb_addr), 15);
    chk("ur_sticky", int'(underrun), 1);
    step(); step();
    pulse(1, 0, 0);
    step(); step();
    rst = 1;
    @(negedge clk_pix);
    chk("midrst_busy", int'(busy), 0);
    step();
    rst = 0;
    @(negedge clk_pix);
    chk("midrst_lb_we", int'(lb_we), 0);
    chk("midrst_rvalid", int'(drw_rvalid), 0);
    chk("midrst_underrun", int'(underrun), 0);
    step();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_pix);
      acc = drw_valid && drw_ready;
      step();
      rst = $urandom_range(0, 399) == 0;
      frame = $urandom_range(0, 59) == 0;
      line = $urandom_range(0, 15) == 0;
      sy = CORDW'(int'($urandom_range(0, 7)) - 2);
      if (!drw_valid || acc) begin
        drw_valid = $urandom_range(0, 1) == 1;
        drw_we = $urandom_range(0, 1) == 1;
        drw_addr = ADDRW'($urandom);
        drw_wdata = DATAW'($urandom);
      end
    end
    rst = 0; frame = 0; line = 0; drw_valid = 0;
    repeat (12) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
